// File: rtl/nn_fixed_pkg.sv
// Shared Q8.8 fixed-point definitions for the network blocks.
// Holds the Q8.8 constants, the 17-bit to 16-bit saturating helper and the
// optimiser FSM state encodings.
package nn_fixed_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam logic [15:0] Q_ONE     = 16'h0100;
  localparam logic [15:0] Q_MAX     = 16'h7FFF;
  localparam logic [15:0] Q_MIN     = 16'h8000;

  // S_DRAIN is only visited when the momentum pipeline is built in.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UPD_W = 3'd1,
    S_UPD_B = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } sgd_state_e;

  // Clamp a 17-bit signed intermediate into signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [16:0] x);
    if (x > 17'sd32767) begin
      return Q_MAX;
    end else if (x < -17'sd32768) begin
      return Q_MIN;
    end else begin
      return x[15:0];
    end
  endfunction

endpackage

// File: rtl/sgd_alu.sv
// Single-element SGD arithmetic: p_new = sat16(p - (lr*g)[23:8]).
// Ports: p (current parameter), g (gradient or velocity), lr (learning rate),
//        p_new (saturated result). All signed Q8.8, purely combinational.
module sgd_alu
  import nn_fixed_pkg::*;
(
  input  logic [15:0] p,
  input  logic [15:0] g,
  input  logic [15:0] lr,
  output logic [15:0] p_new
);

  logic [23:0]        prod;
  logic [15:0]        step;
  logic signed [16:0] diff;

  always_comb begin
    // Only bits [23:0] of the full 32-bit product reach the step, so a
    // 24-bit signed multiply is sufficient.
    prod  = $signed({{8{lr[15]}}, lr}) * $signed({{8{g[15]}}, g});
    step  = 16'(prod >> FRAC_BITS);
    diff  = $signed({p[15], p}) - $signed({step[15], step});
    p_new = sat16(diff);
  end

endmodule

// File: rtl/sgd_update.sv
// SGD parameter store: holds Q8.8 weights/biases and applies
// p <= sat(p - lr*g) one element per cycle after a start pulse.
// Ports: clk, rst_n (async active-low), load/w_init/b_init (store init),
//        start/lr/dL_dw/dL_db (update pass, sampled on start),
//        w/b (store contents), busy, done (one-cycle completion pulse).
// Build option: SGD_MOMENTUM_EN adds per-element velocity and a second
//        pipeline stage (one extra cycle of latency).
module sgd_update
  import nn_fixed_pkg::*;
#(
  parameter int unsigned TOTAL_WEIGHTS = 8,
  parameter int unsigned TOTAL_BIASES  = 4,
  parameter logic [15:0] MOM_BETA      = 16'h00E6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [TOTAL_WEIGHTS*16-1:0] w_init,
  input  logic [TOTAL_BIASES*16-1:0]  b_init,
  input  logic                        start,
  input  logic [15:0]                 lr,
  input  logic [TOTAL_WEIGHTS*16-1:0] dL_dw,
  input  logic [TOTAL_BIASES*16-1:0]  dL_db,
  output logic [TOTAL_WEIGHTS*16-1:0] w,
  output logic [TOTAL_BIASES*16-1:0]  b,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned W_IDX_W = (TOTAL_WEIGHTS > 1) ? $clog2(TOTAL_WEIGHTS) : 1;
  localparam int unsigned B_IDX_W = (TOTAL_BIASES > 1) ? $clog2(TOTAL_BIASES) : 1;
  localparam int unsigned IDX_W   = (W_IDX_W > B_IDX_W) ? W_IDX_W : B_IDX_W;
  localparam logic [IDX_W-1:0] W_LAST = IDX_W'(TOTAL_WEIGHTS - 1);
  localparam logic [IDX_W-1:0] B_LAST = IDX_W'(TOTAL_BIASES - 1);

  sgd_state_e       state, next_state;
  logic [IDX_W-1:0] idx;
  logic [15:0]      lr_q;
  logic [15:0]      gw_q  [TOTAL_WEIGHTS];
  logic [15:0]      gb_q  [TOTAL_BIASES];
  logic [15:0]      w_mem [TOTAL_WEIGHTS];
  logic [15:0]      b_mem [TOTAL_BIASES];

  logic             upd_en, upd_bias;
  logic [15:0]      g_cur;
  logic             wr_en, wr_bias;
  logic [IDX_W-1:0] wr_idx;
  logic [15:0]      alu_p, alu_g, alu_p_new;

  // FSM state plus registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (state != S_IDLE) && (next_state != S_IDLE);
      done  <= (state == S_FIN);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start && !load) next_state = S_UPD_W;
      S_UPD_W: if (idx == W_LAST) next_state = S_UPD_B;
`ifdef SGD_MOMENTUM_EN
      S_UPD_B: if (idx == B_LAST) next_state = S_DRAIN;
`else
      S_UPD_B: if (idx == B_LAST) next_state = S_FIN;
`endif
      S_DRAIN: next_state = S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Element currently addressed by the FSM.
  always_comb begin
    upd_en   = (state == S_UPD_W) || (state == S_UPD_B);
    upd_bias = (state == S_UPD_B);
    g_cur    = upd_bias ? gb_q[idx[B_IDX_W-1:0]] : gw_q[idx[W_IDX_W-1:0]];
  end

`ifdef SGD_MOMENTUM_EN
  logic [15:0]        vel_w [TOTAL_WEIGHTS];
  logic [15:0]        vel_b [TOTAL_BIASES];
  logic [15:0]        v_old, v_new, beta_term;
  logic [23:0]        beta_prod;
  logic signed [16:0] v_sum;
  logic               pipe_vld, pipe_bias;
  logic [IDX_W-1:0]   pipe_idx;
  logic [15:0]        pipe_v;

  // Stage 1: velocity update for the addressed element.
  always_comb begin
    v_old     = upd_bias ? vel_b[idx[B_IDX_W-1:0]] : vel_w[idx[W_IDX_W-1:0]];
    beta_prod = $signed({{8{MOM_BETA[15]}}, MOM_BETA}) * $signed({{8{v_old[15]}}, v_old});
    beta_term = 16'(beta_prod >> FRAC_BITS);
    v_sum     = $signed({beta_term[15], beta_term}) + $signed({g_cur[15], g_cur});
    v_new     = sat16(v_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TOTAL_WEIGHTS; i++) vel_w[i] <= '0;
      for (int i = 0; i < TOTAL_BIASES; i++)  vel_b[i] <= '0;
      pipe_vld  <= 1'b0;
      pipe_bias <= 1'b0;
      pipe_idx  <= '0;
      pipe_v    <= '0;
    end else begin
      pipe_vld  <= upd_en;
      pipe_bias <= upd_bias;
      pipe_idx  <= idx;
      pipe_v    <= v_new;
      if (state == S_IDLE && load) begin
        for (int i = 0; i < TOTAL_WEIGHTS; i++) vel_w[i] <= '0;
        for (int i = 0; i < TOTAL_BIASES; i++)  vel_b[i] <= '0;
      end else if (upd_en) begin
        if (upd_bias) vel_b[idx[B_IDX_W-1:0]] <= v_new;
        else          vel_w[idx[W_IDX_W-1:0]] <= v_new;
      end
    end
  end

  // Stage 2: parameter write from the registered velocity.
  always_comb begin
    wr_en   = pipe_vld;
    wr_bias = pipe_bias;
    wr_idx  = pipe_idx;
    alu_g   = pipe_v;
  end
`else
  always_comb begin
    wr_en   = upd_en;
    wr_bias = upd_bias;
    wr_idx  = idx;
    alu_g   = g_cur;
  end
`endif

  always_comb begin
    alu_p = wr_bias ? b_mem[wr_idx[B_IDX_W-1:0]] : w_mem[wr_idx[W_IDX_W-1:0]];
  end

  sgd_alu u_alu (
    .p     (alu_p),
    .g     (alu_g),
    .lr    (lr_q),
    .p_new (alu_p_new)
  );

  // Parameter store, snapshots and element index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_q <= '0;
      idx  <= '0;
      for (int i = 0; i < TOTAL_WEIGHTS; i++) begin
        w_mem[i] <= '0;
        gw_q[i]  <= '0;
      end
      for (int i = 0; i < TOTAL_BIASES; i++) begin
        b_mem[i] <= '0;
        gb_q[i]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            for (int i = 0; i < TOTAL_WEIGHTS; i++) w_mem[i] <= w_init[i*16 +: 16];
            for (int i = 0; i < TOTAL_BIASES; i++)  b_mem[i] <= b_init[i*16 +: 16];
          end else if (start) begin
            lr_q <= lr;
            idx  <= '0;
            for (int i = 0; i < TOTAL_WEIGHTS; i++) gw_q[i] <= dL_dw[i*16 +: 16];
            for (int i = 0; i < TOTAL_BIASES; i++)  gb_q[i] <= dL_db[i*16 +: 16];
          end
        end
        S_UPD_W: idx <= (idx == W_LAST) ? '0 : idx + IDX_W'(1);
        S_UPD_B: idx <= (idx == B_LAST) ? '0 : idx + IDX_W'(1);
        default: ;
      endcase
      if (wr_en) begin
        if (wr_bias) b_mem[wr_idx[B_IDX_W-1:0]] <= alu_p_new;
        else         w_mem[wr_idx[W_IDX_W-1:0]] <= alu_p_new;
      end
    end
  end

  for (genvar gi = 0; gi < TOTAL_WEIGHTS; gi++) begin : g_w_out
    assign w[gi*16 +: 16] = w_mem[gi];
  end
  for (genvar gi = 0; gi < TOTAL_BIASES; gi++) begin : g_b_out
    assign b[gi*16 +: 16] = b_mem[gi];
  end

endmodule
